// File: rtl/spu_pipe_pkg.sv
// Shared constants and result-entry types for the SPU result/forwarding pipeline.
package spu_pipe_pkg;

   localparam int unsigned DATA_W = 128;
   localparam int unsigned ADDR_W = 7;
   localparam int unsigned DEPTH  = 7;
   localparam int unsigned LAT_W  = 3;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] dest;
      logic [DATA_W-1:0] data;
      logic [LAT_W-1:0]  lat;
   } fwd_entry_t;

   // Index 0 is issue slot 1 (older), index 1 is issue slot 2 (younger).
   typedef fwd_entry_t fwd_stage_t [2];

   function automatic logic [LAT_W-1:0] clamp_lat(input logic [LAT_W-1:0] lat);
      logic [LAT_W-1:0] res;
      res = lat;
      if (lat == '0) begin
         res = LAT_W'(1);
      end else if (lat > LAT_W'(DEPTH)) begin
         res = LAT_W'(DEPTH);
      end
      return res;
   endfunction

endpackage

// File: rtl/spu_result_forward_pipe_if.sv
// EX capture, REG-stage operand lookup and writeback signals of the result pipeline.
interface spu_result_forward_pipe_if;
   import spu_pipe_pkg::*;

   logic              ex1_valid,  ex2_valid;
   logic              ex1_wr_en,  ex2_wr_en;
   logic [ADDR_W-1:0] ex1_dest,   ex2_dest;
   logic [DATA_W-1:0] ex1_result, ex2_result;
   logic [LAT_W-1:0]  ex1_lat,    ex2_lat;

   logic [ADDR_W-1:0] reg1_ra_addr, reg1_rb_addr, reg1_rc_addr;
   logic [ADDR_W-1:0] reg2_ra_addr, reg2_rb_addr, reg2_rc_addr;
   logic [DATA_W-1:0] reg1_ra_rf, reg1_rb_rf, reg1_rc_rf;
   logic [DATA_W-1:0] reg2_ra_rf, reg2_rb_rf, reg2_rc_rf;
   logic [DATA_W-1:0] reg1_ra_op, reg1_rb_op, reg1_rc_op;
   logic [DATA_W-1:0] reg2_ra_op, reg2_rb_op, reg2_rc_op;
   logic              stall;

   logic              wb1_en,   wb2_en;
   logic [ADDR_W-1:0] wb1_addr, wb2_addr;
   logic [DATA_W-1:0] wb1_data, wb2_data;

   modport master (
      output ex1_valid, ex2_valid, ex1_wr_en, ex2_wr_en, ex1_dest, ex2_dest,
             ex1_result, ex2_result, ex1_lat, ex2_lat,
             reg1_ra_addr, reg1_rb_addr, reg1_rc_addr, reg2_ra_addr, reg2_rb_addr, reg2_rc_addr,
             reg1_ra_rf, reg1_rb_rf, reg1_rc_rf, reg2_ra_rf, reg2_rb_rf, reg2_rc_rf,
      input  reg1_ra_op, reg1_rb_op, reg1_rc_op, reg2_ra_op, reg2_rb_op, reg2_rc_op, stall,
             wb1_en, wb2_en, wb1_addr, wb2_addr, wb1_data, wb2_data
   );

   modport slave (
      input  ex1_valid, ex2_valid, ex1_wr_en, ex2_wr_en, ex1_dest, ex2_dest,
             ex1_result, ex2_result, ex1_lat, ex2_lat,
             reg1_ra_addr, reg1_rb_addr, reg1_rc_addr, reg2_ra_addr, reg2_rb_addr, reg2_rc_addr,
             reg1_ra_rf, reg1_rb_rf, reg1_rc_rf, reg2_ra_rf, reg2_rb_rf, reg2_rc_rf,
      output reg1_ra_op, reg1_rb_op, reg1_rc_op, reg2_ra_op, reg2_rb_op, reg2_rc_op, stall,
             wb1_en, wb2_en, wb1_addr, wb2_addr, wb1_data, wb2_data
   );

endinterface

// File: rtl/spu_fwd_lookup.sv
// Resolves one source operand against the live EX slots and every in-flight result stage.
module spu_fwd_lookup
   import spu_pipe_pkg::*;
(
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] rf_i,
   input  logic              ex_valid_i [2],
   input  logic [ADDR_W-1:0] ex_dest_i  [2],
   input  fwd_stage_t        stages_i   [DEPTH],
   output logic [DATA_W-1:0] op_o,
   output logic              stall_req_o
);

   always_comb begin
      op_o        = rf_i;
      stall_req_o = 1'b0;
      // Walk oldest to youngest; a later hit overrides, so the youngest match decides.
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
         for (int s = 0; s < 2; s++) begin
            if (stages_i[k][s].valid && (stages_i[k][s].dest == addr_i)) begin
               if ((k + 1) >= int'(stages_i[k][s].lat)) begin
                  op_o        = stages_i[k][s].data;
                  stall_req_o = 1'b0;
               end else begin
                  op_o        = rf_i;
                  stall_req_o = 1'b1;
               end
            end
         end
      end
      for (int s = 0; s < 2; s++) begin
         if (ex_valid_i[s] && (ex_dest_i[s] == addr_i)) begin
            op_o        = rf_i;
            stall_req_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spu_result_forward_pipe.sv
// Dual-issue result shift pipeline: ages EX results to writeback and forwards them to REG reads.
module spu_result_forward_pipe
   import spu_pipe_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   spu_result_forward_pipe_if.slave bus
);

   localparam int unsigned Last = DEPTH - 1;

   fwd_stage_t        ex_entry;
   fwd_stage_t        stage_d [DEPTH];
   fwd_stage_t        stage_q [DEPTH];
   logic              ex_valid [2];
   logic [ADDR_W-1:0] ex_dest  [2];
   logic [ADDR_W-1:0] rd_addr  [6];
   logic [DATA_W-1:0] rd_rf    [6];
   logic [DATA_W-1:0] rd_op    [6];
   logic [5:0]        stall_req;
   logic              wb_waw;

   always_comb begin
      ex_entry[0].valid = bus.ex1_valid & bus.ex1_wr_en;
      ex_entry[0].dest  = bus.ex1_dest;
      ex_entry[0].data  = bus.ex1_result;
      ex_entry[0].lat   = clamp_lat(bus.ex1_lat);
      ex_entry[1].valid = bus.ex2_valid & bus.ex2_wr_en;
      ex_entry[1].dest  = bus.ex2_dest;
      ex_entry[1].data  = bus.ex2_result;
      ex_entry[1].lat   = clamp_lat(bus.ex2_lat);
      for (int s = 0; s < 2; s++) begin
         ex_valid[s] = ex_entry[s].valid;
         ex_dest[s]  = ex_entry[s].dest;
      end
   end

   always_comb begin
      stage_d[0] = ex_entry;
      for (int k = 1; k < int'(DEPTH); k++) begin
         stage_d[k] = stage_q[k-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < int'(DEPTH); k++) begin
            stage_q[k][0] <= '0;
            stage_q[k][1] <= '0;
         end
      end else begin
         stage_q <= stage_d;
      end
   end

   // Same-stage WAW: slot 2 is younger, so slot 1 must not reach the register file.
   assign wb_waw       = stage_q[Last][0].valid && stage_q[Last][1].valid &&
                         (stage_q[Last][0].dest == stage_q[Last][1].dest);
   assign bus.wb1_en   = stage_q[Last][0].valid & ~wb_waw;
   assign bus.wb1_addr = stage_q[Last][0].dest;
   assign bus.wb1_data = stage_q[Last][0].data;
   assign bus.wb2_en   = stage_q[Last][1].valid;
   assign bus.wb2_addr = stage_q[Last][1].dest;
   assign bus.wb2_data = stage_q[Last][1].data;

   assign rd_addr[0] = bus.reg1_ra_addr;
   assign rd_addr[1] = bus.reg1_rb_addr;
   assign rd_addr[2] = bus.reg1_rc_addr;
   assign rd_addr[3] = bus.reg2_ra_addr;
   assign rd_addr[4] = bus.reg2_rb_addr;
   assign rd_addr[5] = bus.reg2_rc_addr;
   assign rd_rf[0]   = bus.reg1_ra_rf;
   assign rd_rf[1]   = bus.reg1_rb_rf;
   assign rd_rf[2]   = bus.reg1_rc_rf;
   assign rd_rf[3]   = bus.reg2_ra_rf;
   assign rd_rf[4]   = bus.reg2_rb_rf;
   assign rd_rf[5]   = bus.reg2_rc_rf;

   for (genvar i = 0; i < 6; i++) begin : g_lookup
      spu_fwd_lookup u_lookup (
         .addr_i      (rd_addr[i]),
         .rf_i        (rd_rf[i]),
         .ex_valid_i  (ex_valid),
         .ex_dest_i   (ex_dest),
         .stages_i    (stage_q),
         .op_o        (rd_op[i]),
         .stall_req_o (stall_req[i])
      );
   end

   assign bus.reg1_ra_op = rd_op[0];
   assign bus.reg1_rb_op = rd_op[1];
   assign bus.reg1_rc_op = rd_op[2];
   assign bus.reg2_ra_op = rd_op[3];
   assign bus.reg2_rb_op = rd_op[4];
   assign bus.reg2_rc_op = rd_op[5];
   assign bus.stall      = |stall_req;

endmodule

// File: tb/tb_spu_result_forward_pipe.sv
// Directed and randomized checks of the result pipeline against a history-based reference model.
module tb_spu_result_forward_pipe;
   import spu_pipe_pkg::*;

   typedef struct {
      int                cyc;
      int                slot;
      logic [ADDR_W-1:0] dest;
      logic [DATA_W-1:0] data;
      int                lat;
   } rec_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   rec_t hist[$];

   logic [ADDR_W-1:0] rd_addr [6];
   logic [DATA_W-1:0] rd_rf   [6];
   logic [DATA_W-1:0] rd_op   [6];

   spu_result_forward_pipe_if bus ();

   spu_result_forward_pipe dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   assign bus.reg1_ra_addr = rd_addr[0];
   assign bus.reg1_rb_addr = rd_addr[1];
   assign bus.reg1_rc_addr = rd_addr[2];
   assign bus.reg2_ra_addr = rd_addr[3];
   assign bus.reg2_rb_addr = rd_addr[4];
   assign bus.reg2_rc_addr = rd_addr[5];
   assign bus.reg1_ra_rf   = rd_rf[0];
   assign bus.reg1_rb_rf   = rd_rf[1];
   assign bus.reg1_rc_rf   = rd_rf[2];
   assign bus.reg2_ra_rf   = rd_rf[3];
   assign bus.reg2_rb_rf   = rd_rf[4];
   assign bus.reg2_rc_rf   = rd_rf[5];
   assign rd_op[0] = bus.reg1_ra_op;
   assign rd_op[1] = bus.reg1_rb_op;
   assign rd_op[2] = bus.reg1_rc_op;
   assign rd_op[3] = bus.reg2_ra_op;
   assign rd_op[4] = bus.reg2_rb_op;
   assign rd_op[5] = bus.reg2_rc_op;

   function automatic logic [DATA_W-1:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic int eff_lat(input int lat);
      return (lat == 0) ? 1 : ((lat > int'(DEPTH)) ? int'(DEPTH) : lat);
   endfunction

   // Youngest producer of addr: live EX (slot 2 first), then smallest age, slot 2 before slot 1.
   function automatic void model_lookup(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] rf,
                                        output logic [DATA_W-1:0] op, output logic st);
      int best_age = 1000;
      int best_slot = -1;
      int bi = -1;
      op = rf;
      st = 1'b0;
      if ((bus.ex2_valid && bus.ex2_wr_en && bus.ex2_dest == addr) ||
          (bus.ex1_valid && bus.ex1_wr_en && bus.ex1_dest == addr)) begin
         st = 1'b1;
         return;
      end
      foreach (hist[i]) begin
         int age = cyc - hist[i].cyc;
         if (age >= 1 && age <= int'(DEPTH) && hist[i].dest == addr) begin
            if (age < best_age || (age == best_age && hist[i].slot > best_slot)) begin
               best_age  = age;
               best_slot = hist[i].slot;
               bi        = i;
            end
         end
      end
      if (bi >= 0) begin
         if (best_age >= eff_lat(hist[bi].lat)) op = hist[bi].data;
         else st = 1'b1;
      end
   endfunction

   function automatic void model_wb(input int slot, output logic en, output logic [ADDR_W-1:0] addr,
                                    output logic [DATA_W-1:0] data);
      en   = 1'b0;
      addr = '0;
      data = '0;
      foreach (hist[i]) begin
         if (cyc - hist[i].cyc == int'(DEPTH) && hist[i].slot == slot) begin
            en   = 1'b1;
            addr = hist[i].dest;
            data = hist[i].data;
         end
      end
      if (slot == 1 && en) begin
         foreach (hist[i]) begin
            if (cyc - hist[i].cyc == int'(DEPTH) && hist[i].slot == 2 && hist[i].dest == addr)
               en = 1'b0;
         end
      end
   endfunction

   task automatic tick();
      rec_t r;
      if (reset) begin
         hist.delete();
      end else begin
         if (bus.ex1_valid && bus.ex1_wr_en) begin
            r = '{cyc: cyc, slot: 1, dest: bus.ex1_dest, data: bus.ex1_result, lat: int'(bus.ex1_lat)};
            hist.push_back(r);
         end
         if (bus.ex2_valid && bus.ex2_wr_en) begin
            r = '{cyc: cyc, slot: 2, dest: bus.ex2_dest, data: bus.ex2_result, lat: int'(bus.ex2_lat)};
            hist.push_back(r);
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      while (hist.size() > 0 && cyc - hist[0].cyc > int'(DEPTH)) void'(hist.pop_front());
   endtask

   task automatic clear_ex();
      bus.ex1_valid = 0; bus.ex1_wr_en = 0; bus.ex1_dest = '0; bus.ex1_result = '0; bus.ex1_lat = '0;
      bus.ex2_valid = 0; bus.ex2_wr_en = 0; bus.ex2_dest = '0; bus.ex2_result = '0; bus.ex2_lat = '0;
   endtask

   task automatic idle_reads();
      for (int i = 0; i < 6; i++) begin
         rd_addr[i] = ADDR_W'(100 + i);
         rd_rf[i]   = rnd128();
      end
   endtask

   task automatic do_reset();
      clear_ex();
      idle_reads();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #2;
      checks++;
      if (bus.wb1_en !== 1'b0 || bus.wb2_en !== 1'b0) begin
         errors++; $display("FAIL reset_wb_en: got %b%b expected 00", bus.wb1_en, bus.wb2_en);
      end
      checks++;
      if (bus.wb1_addr !== '0 || bus.wb2_addr !== '0 || bus.wb1_data !== '0 || bus.wb2_data !== '0) begin
         errors++; $display("FAIL reset_wb_fields: got %h %h expected zero", bus.wb1_addr, bus.wb2_addr);
      end
      checks++;
      if (bus.stall !== 1'b0) begin
         errors++; $display("FAIL reset_stall: got %b expected 0", bus.stall);
      end
      checks++;
      if (rd_op[4] !== rd_rf[4]) begin
         errors++; $display("FAIL reset_op: got %h expected %h", rd_op[4], rd_rf[4]);
      end
      tick();
   endtask

   task automatic test_wb_and_forward();
      do_reset();
      rd_addr[0] = 7'd5;
      for (int c = 0; c < 10; c++) begin
         clear_ex();
         if (c == 0) begin
            bus.ex1_valid = 1; bus.ex1_wr_en = 1; bus.ex1_dest = 7'd5;
            bus.ex1_result = 128'hA5; bus.ex1_lat = 3'd2;
         end
         #2;
         checks++;
         if (bus.stall !== (c <= 1)) begin
            errors++; $display("FAIL fwd_stall c%0d: got %b expected %b", c, bus.stall, c <= 1);
         end
         if (c >= 2 && c <= 7) begin
            checks++;
            if (rd_op[0] !== 128'hA5) begin
               errors++; $display("FAIL fwd_ready c%0d: got %h expected a5", c, rd_op[0]);
            end
         end
         if (c >= 8) begin
            checks++;
            if (rd_op[0] !== rd_rf[0]) begin
               errors++; $display("FAIL fwd_retired c%0d: got %h expected %h", c, rd_op[0], rd_rf[0]);
            end
         end
         checks++;
         if (bus.wb1_en !== (c == 7) || bus.wb2_en !== 1'b0) begin
            errors++; $display("FAIL wb_en c%0d: got %b%b expected %b0", c, bus.wb1_en, bus.wb2_en, c == 7);
         end
         if (c == 7) begin
            checks++;
            if (bus.wb1_addr !== 7'd5 || bus.wb1_data !== 128'hA5) begin
               errors++; $display("FAIL wb_fields: got %h/%h expected 05/a5", bus.wb1_addr, bus.wb1_data);
            end
         end
         tick();
      end
   endtask

   task automatic test_youngest();
      do_reset();
      rd_addr[5] = 7'd9;
      for (int c = 0; c < 4; c++) begin
         clear_ex();
         if (c < 2) begin
            bus.ex1_valid = 1; bus.ex1_wr_en = 1; bus.ex1_dest = 7'd9; bus.ex1_lat = 3'd1;
            bus.ex1_result = (c == 0) ? 128'h11 : 128'h22;
         end
         #2;
         checks++;
         if (bus.stall !== (c < 2)) begin
            errors++; $display("FAIL youngest_stall c%0d: got %b expected %b", c, bus.stall, c < 2);
         end
         if (c >= 2) begin
            checks++;
            if (rd_op[5] !== 128'h22) begin
               errors++; $display("FAIL youngest_op c%0d: got %h expected 22", c, rd_op[5]);
            end
         end
         tick();
      end
   endtask

   task automatic test_waw();
      do_reset();
      rd_addr[1] = 7'd3;
      for (int c = 0; c < 9; c++) begin
         clear_ex();
         if (c == 0) begin
            bus.ex1_valid = 1; bus.ex1_wr_en = 1; bus.ex1_dest = 7'd3; bus.ex1_result = 128'h1;
            bus.ex1_lat = 3'd1;
            bus.ex2_valid = 1; bus.ex2_wr_en = 1; bus.ex2_dest = 7'd3; bus.ex2_result = 128'h2;
            bus.ex2_lat = 3'd0;
         end
         #2;
         if (c >= 1 && c <= 7) begin
            checks++;
            if (rd_op[1] !== 128'h2 || bus.stall !== 1'b0) begin
               errors++; $display("FAIL waw_fwd c%0d: got %h/%b expected 2/0", c, rd_op[1], bus.stall);
            end
         end
         checks++;
         if (bus.wb1_en !== 1'b0 || bus.wb2_en !== (c == 7)) begin
            errors++; $display("FAIL waw_en c%0d: got %b%b expected 0%b", c, bus.wb1_en, bus.wb2_en, c == 7);
         end
         if (c == 7) begin
            checks++;
            if (bus.wb2_addr !== 7'd3 || bus.wb2_data !== 128'h2) begin
               errors++; $display("FAIL waw_wb2: got %h/%h expected 03/2", bus.wb2_addr, bus.wb2_data);
            end
         end
         tick();
      end
   endtask

   task automatic test_ex_hazard_reset();
      do_reset();
      for (int c = 0; c < 3; c++) begin
         clear_ex();
         if (c == 0) begin
            bus.ex2_valid = 1; bus.ex2_wr_en = 1; bus.ex2_dest = 7'd20; bus.ex2_result = 128'hBEEF;
            bus.ex2_lat = 3'd3;
            bus.ex1_valid = 1; bus.ex1_wr_en = 1; bus.ex1_dest = 7'd21; bus.ex1_result = 128'hCAFE;
            bus.ex1_lat = 3'd1;
            rd_addr[1] = 7'd20;
         end else if (c == 1) begin
            bus.ex1_valid = 1; bus.ex1_wr_en = 1; bus.ex1_dest = 7'd22; bus.ex1_result = 128'hF00D;
            bus.ex1_lat = 3'd1;
            rd_addr[1] = 7'd21;
         end else begin
            rd_addr[1] = 7'd20;
         end
         #2;
         checks++;
         if (bus.stall !== (c != 1)) begin
            errors++; $display("FAIL hazard_stall c%0d: got %b expected %b", c, bus.stall, c != 1);
         end
         if (c == 1) begin
            checks++;
            if (rd_op[1] !== 128'hCAFE) begin
               errors++; $display("FAIL hazard_fwd: got %h expected cafe", rd_op[1]);
            end
         end
         tick();
      end
      clear_ex();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      rd_addr[0] = 7'd20; rd_addr[1] = 7'd21; rd_addr[2] = 7'd22;
      for (int c = 0; c < 10; c++) begin
         #2;
         checks++;
         if (bus.wb1_en !== 1'b0 || bus.wb2_en !== 1'b0 || bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL flush c%0d: got en %b%b stall %b expected 000", c, bus.wb1_en, bus.wb2_en,
                     bus.stall);
         end
         checks++;
         if (rd_op[0] !== rd_rf[0] || rd_op[1] !== rd_rf[1] || rd_op[2] !== rd_rf[2]) begin
            errors++; $display("FAIL flush_op c%0d: got %h expected %h", c, rd_op[1], rd_rf[1]);
         end
         tick();
      end
   endtask

   task automatic test_random();
      logic [DATA_W-1:0] eop;
      logic              est;
      logic              any_st;
      logic              een;
      logic [ADDR_W-1:0] eaddr;
      logic [DATA_W-1:0] edata;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         reset = ($urandom_range(0, 59) == 0);
         bus.ex1_valid = ($urandom_range(0, 3) != 0); bus.ex1_wr_en = ($urandom_range(0, 5) != 0);
         bus.ex1_dest = ADDR_W'($urandom_range(0, 7)); bus.ex1_result = rnd128();
         bus.ex1_lat = 3'($urandom_range(0, 7));
         bus.ex2_valid = ($urandom_range(0, 3) != 0); bus.ex2_wr_en = ($urandom_range(0, 5) != 0);
         bus.ex2_dest = ADDR_W'($urandom_range(0, 7)); bus.ex2_result = rnd128();
         bus.ex2_lat = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) bus.ex1_valid = 0;
         for (int i = 0; i < 6; i++) begin
            rd_addr[i] = ADDR_W'($urandom_range(0, 11));
            rd_rf[i]   = rnd128();
         end
         #2;
         any_st = 1'b0;
         for (int i = 0; i < 6; i++) begin
            model_lookup(rd_addr[i], rd_rf[i], eop, est);
            any_st |= est;
            if (!est) begin
               checks++;
               if (rd_op[i] !== eop) begin
                  errors++; $display("FAIL rand_op%0d c%0d: got %h expected %h", i, c, rd_op[i], eop);
               end
            end
         end
         checks++;
         if (bus.stall !== any_st) begin
            errors++; $display("FAIL rand_stall c%0d: got %b expected %b", c, bus.stall, any_st);
         end
         model_wb(1, een, eaddr, edata);
         checks++;
         if (bus.wb1_en !== een || (een && (bus.wb1_addr !== eaddr || bus.wb1_data !== edata))) begin
            errors++; $display("FAIL rand_wb1 c%0d: got %b/%h expected %b/%h", c, bus.wb1_en,
                               bus.wb1_addr, een, eaddr);
         end
         model_wb(2, een, eaddr, edata);
         checks++;
         if (bus.wb2_en !== een || (een && (bus.wb2_addr !== eaddr || bus.wb2_data !== edata))) begin
            errors++; $display("FAIL rand_wb2 c%0d: got %b/%h expected %b/%h", c, bus.wb2_en,
                               bus.wb2_addr, een, eaddr);
         end
         tick();
      end
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation still running, expected finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      clear_ex();
      idle_reads();
      @(posedge clk);
      #1;
      test_reset();
      test_wb_and_forward();
      test_youngest();
      test_waw();
      test_ex_hazard_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
